// File: rtl/urv_mem_arbiter.sv
// Arbitrates one single-port memory bus between the uRV fetch and data ports.
// Data wins by default; a starvation counter forces a fetch after g_starve_limit data grants.
module urv_mem_arbiter #(
    parameter int unsigned g_starve_limit = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] im_addr_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_sel_o,
    output logic        mem_we_o,
    output logic        mem_req_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 4;
    localparam logic [AW-1:0] WORD_MASK  = ~AW'(3);
    localparam logic [CW-1:0] STARVE_MAX = CW'(g_starve_limit);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_FETCH} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
    } dreq_t;

    state_t        state_q, state_d;
    dreq_t         pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic          fb_valid_q, fb_valid_d;
    logic [AW-1:0] fb_addr_q, fb_addr_d;
    logic [DW-1:0] fb_data_q, fb_data_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic [SW-1:0] mem_sel_q, mem_sel_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_req_q, mem_req_d;
    logic [DW-1:0] dm_data_l_q, dm_data_l_d;
    logic          load_done_q, load_done_d;
    logic          store_done_q, store_done_d;
    logic          fetch_want;

    // Buffer hit is combinational so a branch invalidates the word immediately.
    assign im_valid_o      = fb_valid_q && (fb_addr_q == (im_addr_i & WORD_MASK));
    assign im_data_o       = fb_data_q;
    assign fetch_want      = !im_valid_o;
    assign dm_ready_o      = !pend_valid_q;
    assign dm_data_l_o     = dm_data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_data_o      = mem_data_q;
    assign mem_sel_o       = mem_sel_q;
    assign mem_we_o        = mem_we_q;
    assign mem_req_o       = mem_req_q;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        fb_valid_d   = fb_valid_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        starve_d     = starve_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_sel_d    = mem_sel_q;
        mem_we_d     = mem_we_q;
        mem_req_d    = mem_req_q;
        dm_data_l_d  = dm_data_l_q;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;

        // Capture a data request; store wins when both strobes are high.
        if (!pend_valid_q && (dm_load_i || dm_store_i)) begin
            pend_valid_d = 1'b1;
            pend_d.we    = dm_store_i;
            pend_d.addr  = dm_addr_i & WORD_MASK;
            pend_d.data  = dm_data_s_i;
            pend_d.sel   = dm_store_i ? dm_data_select_i : SW'(4'hF);
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q && ((starve_q < STARVE_MAX) || !fetch_want)) begin
                    state_d    = ST_DATA;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pend_q.addr;
                    mem_data_d = pend_q.data;
                    mem_sel_d  = pend_q.sel;
                    mem_we_d   = pend_q.we;
                    if (fetch_want && (starve_q < STARVE_MAX)) begin
                        starve_d = starve_q + CW'(1);
                    end
                end else if (fetch_want) begin
                    state_d    = ST_FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = im_addr_i & WORD_MASK;
                    mem_sel_d  = SW'(4'hF);
                    mem_we_d   = 1'b0;
                    starve_d   = '0;
                end
            end
            ST_DATA: begin
                if (mem_ack_i) begin
                    state_d      = ST_IDLE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    pend_valid_d = 1'b0;
                    if (pend_q.we) begin
                        store_done_d = 1'b1;
                    end else begin
                        load_done_d = 1'b1;
                        dm_data_l_d = mem_data_i;
                    end
                end
            end
            ST_FETCH: begin
                // Written even if the CPU branched away; the hit compare rejects it.
                if (mem_ack_i) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    fb_valid_d = 1'b1;
                    fb_addr_d  = mem_addr_q;
                    fb_data_d  = mem_data_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            fb_valid_q   <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            starve_q     <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_sel_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            dm_data_l_q  <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            fb_valid_q   <= fb_valid_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            starve_q     <= starve_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_sel_q    <= mem_sel_d;
            mem_we_q     <= mem_we_d;
            mem_req_q    <= mem_req_d;
            dm_data_l_q  <= dm_data_l_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
        end
    end

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Directed bench for urv_mem_arbiter: bus-transaction and load-data scoreboards,
// a behavioural memory responder, and immediate assertions at each check.
module tb_urv_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] im_addr_i, im_data_o;
    logic        im_valid_o;
    logic [31:0] dm_addr_i, dm_data_s_i, dm_data_l_o;
    logic [3:0]  dm_data_select_i;
    logic        dm_load_i, dm_store_i, dm_ready_o, dm_load_done_o, dm_store_done_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic [3:0]  mem_sel_o;
    logic        mem_we_o, mem_req_o, mem_ack_i;

    always #5 clk_i = ~clk_i;

    urv_mem_arbiter #(.g_starve_limit(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .im_addr_i(im_addr_i), .im_data_o(im_data_o), .im_valid_o(im_valid_o),
        .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
        .dm_load_i(dm_load_i), .dm_store_i(dm_store_i), .dm_ready_o(dm_ready_o),
        .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
        .dm_store_done_o(dm_store_done_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_sel_o(mem_sel_o),
        .mem_we_o(mem_we_o), .mem_req_o(mem_req_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } txn_t;

    txn_t        sb_q[$];
    logic [31:0] ld_q[$];
    logic [31:0] mem_words [logic [31:0]];

    int n_assert = 0, n_fail = 0;
    int cyc = 0, last_ack_cyc = -10, ld_done_cyc = 0;
    int n_load_done = 0, n_store_done = 0;
    int resp_wait = 0, wait_cnt = 0;
    logic resp_en = 1'b0, resp_ack = 1'b0, man_ack = 1'b0;
    logic [31:0] resp_data = '0;

    assign mem_ack_i  = resp_en ? resp_ack : man_ack;
    assign mem_data_i = resp_en ? resp_data : 32'hBAD0_BAD0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return dflt(a);
    endfunction

    task automatic push_txn(input logic [31:0] a, input logic we, input logic [3:0] sel,
                            input logic [31:0] wd);
        txn_t t;
        t.addr = a; t.we = we; t.sel = sel; t.wdata = wd;
        sb_q.push_back(t);
    endtask

    // Memory responder: acks after resp_wait cycles of request, checks each transaction.
    always @(negedge clk_i) begin
        txn_t t;
        logic [31:0] w;
        resp_ack = 1'b0;
        if (resp_en && mem_req_o) begin
            if (wait_cnt >= resp_wait) begin
                wait_cnt     = 0;
                resp_ack     = 1'b1;
                resp_data    = rd_mem(mem_addr_o);
                last_ack_cyc = cyc;
                chkb("bus_txn_expected", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    t = sb_q.pop_front();
                    chk("bus_addr", mem_addr_o, t.addr);
                    chkb("bus_we", mem_we_o, t.we);
                    chk("bus_sel", 32'(mem_sel_o), 32'(t.sel));
                    if (t.we) chk("bus_wdata", mem_data_o, t.wdata);
                end
                if (mem_we_o) begin
                    w = rd_mem(mem_addr_o);
                    for (int b = 0; b < 4; b++)
                        if (mem_sel_o[b]) w[8*b +: 8] = mem_data_o[8*b +: 8];
                    mem_words[mem_addr_o] = w;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Output monitor: done pulses, load data and fetch-buffer contents.
    always @(negedge clk_i) begin
        logic [31:0] e;
        #1;
        if (dm_load_done_o) begin
            n_load_done++;
            ld_done_cyc = cyc;
            chk("load_done_at_ack_plus1", 32'(cyc), 32'(last_ack_cyc + 1));
            chkb("load_done_expected", ld_q.size() != 0, 1'b1);
            if (ld_q.size() != 0) begin
                e = ld_q.pop_front();
                chk("load_data", dm_data_l_o, e);
            end
        end
        if (dm_store_done_o) begin
            n_store_done++;
            chk("store_done_at_ack_plus1", 32'(cyc), 32'(last_ack_cyc + 1));
        end
        if (im_valid_o) chk("im_data_vs_mem", im_data_o, rd_mem(im_addr_i & 32'hFFFF_FFFC));
    end

    initial begin
        int st0, ld0, req_cyc;
        logic [31:0] w, fb_track;
        rst_i = 1'b1; im_addr_i = 32'h100;
        dm_addr_i = '0; dm_data_s_i = '0; dm_data_select_i = '0;
        dm_load_i = 1'b0; dm_store_i = 1'b0;
        mem_words[32'h100] = 32'h0000_0013;

        // Reset values
        repeat (2) @(negedge clk_i);
        #1;
        chkb("rst_mem_req", mem_req_o, 1'b0);
        chkb("rst_mem_we", mem_we_o, 1'b0);
        chkb("rst_load_done", dm_load_done_o, 1'b0);
        chkb("rst_store_done", dm_store_done_o, 1'b0);
        chkb("rst_im_valid", im_valid_o, 1'b0);
        chkb("rst_dm_ready", dm_ready_o, 1'b1);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 32'h0);
        chk("rst_dm_data_l", dm_data_l_o, 32'h0);
        chk("rst_im_data", im_data_o, 32'h0);
        chk("rst_mem_sel", 32'(mem_sel_o), 32'h0);

        // Reset mid-fetch, then a late ack in IDLE
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 20 && !mem_req_o; i++) @(negedge clk_i);
        chkb("first_fetch_req", mem_req_o, 1'b1);
        chk("first_fetch_addr", mem_addr_o, 32'h100);
        rst_i = 1'b1;
        @(negedge clk_i);
        #1 chkb("mid_rst_req_low", mem_req_o, 1'b0);
        rst_i = 1'b0; man_ack = 1'b1;
        @(negedge clk_i);
        man_ack = 1'b0;
        #1;
        chkb("late_ack_no_load_done", dm_load_done_o, 1'b0);
        chkb("late_ack_no_store_done", dm_store_done_o, 1'b0);
        chkb("late_ack_no_im_valid", im_valid_o, 1'b0);
        chkb("refetch_after_rst", mem_req_o, 1'b1);

        // Fetch only
        push_txn(32'h100, 1'b0, 4'hF, 32'h0);
        resp_en = 1'b1;
        for (int i = 0; i < 20 && !im_valid_o; i++) @(negedge clk_i);
        #1 chkb("fetch_100_valid", im_valid_o, 1'b1);
        chk("fetch_100_data", im_data_o, 32'h0000_0013);
        @(negedge clk_i);
        push_txn(32'h104, 1'b0, 4'hF, 32'h0);
        im_addr_i = 32'h104;
        #1 chkb("branch_drops_valid", im_valid_o, 1'b0);
        for (int i = 0; i < 20 && !im_valid_o; i++) @(negedge clk_i);
        #1 chkb("fetch_104_valid", im_valid_o, 1'b1);
        chk("fetch_104_data", im_data_o, dflt(32'h104));

        // Store with partial byte enables to an unaligned address
        @(negedge clk_i);
        st0 = n_store_done;
        push_txn(32'h2000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        dm_addr_i = 32'h2002; dm_data_s_i = 32'hDEAD_BEEF; dm_data_select_i = 4'b0011;
        dm_store_i = 1'b1;
        @(negedge clk_i);
        dm_store_i = 1'b0;
        #1 chkb("ready_low_after_req", dm_ready_o, 1'b0);
        for (int i = 0; i < 20 && n_store_done == st0; i++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        chk("store_one_pulse", 32'(n_store_done - st0), 32'd1);

        // Load with two wait states sees the merged store data
        resp_wait = 2;
        ld0 = n_load_done;
        w = dflt(32'h2000);
        ld_q.push_back({w[31:16], 16'hBEEF});
        push_txn(32'h2000, 1'b0, 4'hF, 32'h0);
        dm_addr_i = 32'h2000; dm_load_i = 1'b1;
        @(negedge clk_i);
        dm_load_i = 1'b0;
        for (int i = 0; i < 30 && n_load_done == ld0; i++) @(negedge clk_i);
        chk("load_ws_one_done", 32'(n_load_done - ld0), 32'd1);
        resp_wait = 0;

        // Zero-wait load latency
        @(negedge clk_i);
        ld0 = n_load_done;
        ld_q.push_back(dflt(32'h2004));
        push_txn(32'h2004, 1'b0, 4'hF, 32'h0);
        dm_addr_i = 32'h2004; dm_load_i = 1'b1; req_cyc = cyc;
        @(negedge clk_i);
        dm_load_i = 1'b0;
        for (int i = 0; i < 20 && n_load_done == ld0; i++) @(negedge clk_i);
        #2 chk("load_latency", 32'(ld_done_cyc - req_cyc), 32'd3);

        // Load and store together: only the store runs
        @(negedge clk_i);
        st0 = n_store_done; ld0 = n_load_done;
        push_txn(32'h2008, 1'b1, 4'hF, 32'h1234_5678);
        dm_addr_i = 32'h2008; dm_data_s_i = 32'h1234_5678; dm_data_select_i = 4'hF;
        dm_load_i = 1'b1; dm_store_i = 1'b1;
        @(negedge clk_i);
        dm_load_i = 1'b0; dm_store_i = 1'b0;
        for (int i = 0; i < 20 && n_store_done == st0; i++) @(negedge clk_i);
        repeat (3) @(negedge clk_i);
        chk("both_store_done", 32'(n_store_done - st0), 32'd1);
        chk("both_no_load_done", 32'(n_load_done - ld0), 32'd0);

        // Request while not ready is ignored
        st0 = n_store_done; ld0 = n_load_done;
        ld_q.push_back(dflt(32'h200C));
        push_txn(32'h200C, 1'b0, 4'hF, 32'h0);
        dm_addr_i = 32'h200C; dm_load_i = 1'b1;
        @(negedge clk_i);
        dm_load_i = 1'b0;
        dm_addr_i = 32'h3000; dm_data_s_i = 32'h0000_CAFE; dm_store_i = 1'b1;
        #1 chkb("busy_not_ready", dm_ready_o, 1'b0);
        @(negedge clk_i);
        dm_store_i = 1'b0;
        for (int i = 0; i < 20 && n_load_done == ld0; i++) @(negedge clk_i);
        repeat (5) @(negedge clk_i);
        chk("ignored_no_store", 32'(n_store_done - st0), 32'd0);
        chk("ignored_sb_drained", 32'(sb_q.size()), 32'd0);

        // Branch while a fetch is outstanding
        resp_wait = 3;
        push_txn(32'h100, 1'b0, 4'hF, 32'h0);
        im_addr_i = 32'h100;
        for (int i = 0; i < 20 && !mem_req_o; i++) @(negedge clk_i);
        chkb("branch_fetch_req", mem_req_o, 1'b1);
        push_txn(32'h200, 1'b0, 4'hF, 32'h0);
        im_addr_i = 32'h200;
        for (int i = 0; i < 40 && !im_valid_o; i++) @(negedge clk_i);
        #1 chkb("fetch_200_valid", im_valid_o, 1'b1);
        chk("fetch_200_data", im_data_o, dflt(32'h200));
        resp_wait = 0;

        // Starvation (limit 2): grant order D D F D D F, then the final fetch
        @(negedge clk_i);
        push_txn(32'h3000, 1'b0, 4'hF, 32'h0);
        push_txn(32'h3004, 1'b0, 4'hF, 32'h0);
        push_txn(32'h8020, 1'b0, 4'hF, 32'h0);
        push_txn(32'h3008, 1'b0, 4'hF, 32'h0);
        push_txn(32'h300C, 1'b0, 4'hF, 32'h0);
        push_txn(32'h8040, 1'b0, 4'hF, 32'h0);
        push_txn(32'h3010, 1'b0, 4'hF, 32'h0);
        push_txn(32'h8044, 1'b0, 4'hF, 32'h0);
        for (int k = 0; k < 5; k++) ld_q.push_back(dflt(32'h3000 + 32'(4 * k)));
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 20 && !dm_ready_o; i++) @(negedge clk_i);
            chkb("starve_ready", dm_ready_o, 1'b1);
            fb_track = (k >= 3) ? 32'h8020 : 32'h200;
            im_addr_i = fb_track;
            dm_addr_i = 32'h3000 + 32'(4 * k); dm_load_i = 1'b1;
            @(negedge clk_i);
            dm_load_i = 1'b0;
            im_addr_i = 32'h8000 + 32'(16 * k);
            @(negedge clk_i);
            im_addr_i = 32'h8004 + 32'(16 * k);
            @(negedge clk_i);
        end
        for (int i = 0; i < 40 && !im_valid_o; i++) @(negedge clk_i);
        #1 chkb("starve_final_fetch", im_valid_o, 1'b1);
        repeat (3) @(negedge clk_i);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("final_ld_q_empty", 32'(ld_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/urv_mem_arbiter.md
# urv_mem_arbiter

Shares one single-port memory bus between the uRV CPU instruction-fetch port (`im_*`) and data port (`dm_*`), so a CPU can run from a single unified RAM or bus slave. Data accesses have priority because the CPU stalls on them. A bounded-starvation counter guarantees forward progress for fetches. The block sits between `urv_cpu` and the memory and owns all sequencing of the shared bus.

## Interface

**Parameters**
- `g_starve_limit`, default 4: maximum consecutive data grants while a fetch is waiting; the next grant is forced to fetch. Range 1..15.

**Ports**
- `clk_i` in 1: clock. One clock only.
- `rst_i` in 1: reset, synchronous, active-high.
- `im_addr_i` in 32: fetch address from CPU; may change any cycle.
- `im_data_o` out 32: fetched word.
- `im_valid_o` out 1: `im_data_o` holds the word at the current `im_addr_i`.
- `dm_addr_i` in 32: data address.
- `dm_data_s_i` in 32: store data.
- `dm_data_select_i` in 4: byte enables.
- `dm_load_i` in 1: load request pulse.
- `dm_store_i` in 1: store request pulse.
- `dm_ready_o` out 1: arbiter can accept a data request this cycle.
- `dm_data_l_o` out 32: load data.
- `dm_load_done_o` out 1: one-cycle load-complete pulse.
- `dm_store_done_o` out 1: one-cycle store-complete pulse.
- `mem_addr_o` out 32: bus address. Word-aligned: bits [1:0] forced to 0.
- `mem_data_o` out 32: bus write data.
- `mem_sel_o` out 4: bus byte enables. `4'hF` for fetch and load.
- `mem_we_o` out 1: write strobe qualifier.
- `mem_req_o` out 1: bus request, held until ack.
- `mem_data_i` in 32: bus read data, valid with ack.
- `mem_ack_i` in 1: bus completion, one cycle.

## Operation

**Data request capture**
- `dm_load_i` or `dm_store_i` sampled only when `dm_ready_o`=1. The arbiter latches address, data and select into a one-entry pending register.
- Requests while `dm_ready_o`=0 are ignored.
- `dm_load_i` and `dm_store_i` both high: the store is taken and the load is dropped.
- `dm_ready_o` = no data request pending and none in flight.

**Fetch buffer**
- One entry: `fb_valid`, `fb_addr`, `fb_data`.
- `im_valid_o` = `fb_valid && fb_addr == {im_addr_i[31:2],2'b00}`. This is combinational, so a branch (address change) drops valid the same cycle.
- A fetch is wanted when `im_valid_o`=0.
- A fetch whose address no longer matches `im_addr_i` on ack is still written to the buffer. `im_valid_o` then evaluates false and a new fetch is issued. No stale data is ever flagged valid.

**FSM states and transitions**
- IDLE → DATA when a data request is pending and (`starve_cnt` < `g_starve_limit` or no fetch is wanted).
- IDLE → FETCH when a fetch is wanted and (no data request pending or `starve_cnt` == `g_starve_limit`).
- DATA → IDLE on `mem_ack_i`.
- FETCH → IDLE on `mem_ack_i`.
- Leaving DATA with a load: latch `dm_data_l_o` ← `mem_data_i` and pulse `dm_load_done_o`.
- Leaving DATA with a store: pulse `dm_store_done_o`.
- Leaving FETCH: write `fb_addr`/`fb_data` and set `fb_valid`.

**Starvation counter**
- `starve_cnt` (4 bits) increments on each data grant made while a fetch is wanted.
- It clears on any fetch grant, and saturates at `g_starve_limit`.

**Output behaviour**
- All memory-side outputs are registered.
- `mem_req_o` is high for the whole of DATA and FETCH.
- `mem_ack_i` is ignored in IDLE.
- `dm_data_l_o` holds its last value until the next load completes.

**Reset (including mid-transaction)**
- State → IDLE; pending register and `fb_valid` cleared; `starve_cnt` = 0.
- Any bus transaction in flight is abandoned; a late ack arrives in IDLE and is ignored.

## Timing

**Reset values**
- `mem_req_o`, `mem_we_o`, `dm_load_done_o`, `dm_store_done_o`, `im_valid_o` = 0.
- `dm_ready_o` = 1.
- `mem_addr_o`, `mem_data_o`, `dm_data_l_o`, `im_data_o` = 0.
- `mem_sel_o` = 0.

**Cycle-level sequence**
- Request sampled in cycle T; grant decided in IDLE at T+1; `mem_req_o` high from T+2.
- `mem_ack_i` in cycle N (N ≥ first req cycle; zero-wait allowed): `mem_req_o` low at N+1, done pulse / fetch buffer update visible at N+1, FSM in IDLE at N+1.
- The next `mem_req_o` is at N+2 earliest, giving one idle bus cycle between transactions.
- Minimum load latency, `dm_load_i` to `dm_load_done_o`, with zero-wait memory: 3 cycles.
- `dm_ready_o` returns to 1 in the cycle of the done pulse. A new request is accepted that same cycle.

## Test plan

1. **Reset:** assert `rst_i` 2 cycles → all outputs at their reset values, `dm_ready_o`=1. Assert reset with `mem_req_o`=1, then ack → no done pulse, no `im_valid_o`.
2. **Fetch only:** `im_addr_i`=0x100, memory returns 0x00000013 with zero wait → `mem_addr_o`=0x100, `mem_sel_o`=F, `im_valid_o`=1 with `im_data_o`=0x13. Change to 0x104 → `im_valid_o` drops the same cycle, then refetch.
3. **Load/store:** store 0xDEADBEEF, sel 4'b0011, to 0x2002 → `mem_addr_o`=0x2000, `mem_we_o`=1, one `dm_store_done_o` pulse. Load from 0x2000 with 2 wait states → `dm_load_done_o` at ack+1 with `dm_data_l_o`=mem data.
4. **Starvation:** `g_starve_limit`=2, back-to-back loads while the fetch misses → grant order D, D, F, D, D, F.
5. **Branch during fetch:** `im_addr_i` changes 0x100→0x200 while the 0x100 fetch is outstanding → `im_valid_o` never high for 0x200 with 0x100's data; the 0x200 fetch follows.
6. **Simultaneous/illegal:** `dm_load_i` and `dm_store_i` both high → only the store is performed. Request while `dm_ready_o`=0 → ignored, no bus activity.
